mux_diag_engine: RTL and testbench

Parametrised, clocked self-test engine for an N:1 multiplexer under diagnosis. On `start` it drives every input combination into the mux, waits a programmable settle time, and compares the mux's internal tap bus against a golden model. It accumulates per-wire mismatch information, so a run reports which wires are faulty, not just that a fault exists. It sits between the diagnosis controller and the mux under test, replacing per-vector bench checking with a synthesizable engine.

---
 rtl/mux_diag_pkg.sv | 43 ++++
 rtl/mux_diag_engine_if.sv | 52 +++++
 rtl/mux_golden_model.sv | 39 +++
 rtl/mux_diag_engine.sv | 157 +++++++++++++++
 tb/tb_mux_diag_engine.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_diag_pkg.sv
// Shared types and tap-layout helpers for the mux diagnosis engine.
// Tap bus layout, LSB first: data, sel, decode, and-terms, out.
package mux_diag_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck,
    StDone
  } diag_state_e;

  // Number of data inputs of the mux under test.
  function automatic int unsigned n_in(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

  // Width of the observed tap bus.
  function automatic int unsigned tap_w(input int unsigned sel_w);
    return 3 * n_in(sel_w) + sel_w + 1;
  endfunction

  function automatic int unsigned data_off();
    return 0;
  endfunction

  function automatic int unsigned sel_off(input int unsigned sel_w);
    return n_in(sel_w);
  endfunction

  function automatic int unsigned dec_off(input int unsigned sel_w);
    return n_in(sel_w) + sel_w;
  endfunction

  function automatic int unsigned and_off(input int unsigned sel_w);
    return 2 * n_in(sel_w) + sel_w;
  endfunction

  function automatic int unsigned out_off(input int unsigned sel_w);
    return 3 * n_in(sel_w) + sel_w;
  endfunction

endpackage

// File: rtl/mux_diag_engine_if.sv
// Bus between the diagnosis controller / mux under test and the engine.
// master: the environment side (issues start, returns taps); slave: the engine.
interface mux_diag_engine_if
  import mux_diag_pkg::*;
#(
  parameter int unsigned SEL_W = 1
);
  localparam int unsigned N_IN  = n_in(SEL_W);
  localparam int unsigned VW    = SEL_W + N_IN;
  localparam int unsigned TAP_W = tap_w(SEL_W);

  logic             start;
  logic [N_IN-1:0]  stim_data;
  logic [SEL_W-1:0] stim_sel;
  logic [TAP_W-1:0] taps;
  logic             busy;
  logic             done;
  logic             pass;
  logic [TAP_W-1:0] err_mask;
  logic [VW:0]      fail_cnt;
  logic [VW-1:0]    first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start,
    output taps,
    input  stim_data,
    input  stim_sel,
    input  busy,
    input  done,
    input  pass,
    input  err_mask,
    input  fail_cnt,
    input  first_fail_vec,
    input  first_fail_valid
  );

  modport slave (
    input  start,
    input  taps,
    output stim_data,
    output stim_sel,
    output busy,
    output done,
    output pass,
    output err_mask,
    output fail_cnt,
    output first_fail_vec,
    output first_fail_valid
  );

endinterface

// File: rtl/mux_golden_model.sv
// Fault-free reference of the N:1 mux: maps sel/data to the expected tap bus.
// Purely combinational; also usable as a loopback mux under test.
module mux_golden_model
  import mux_diag_pkg::*;
#(
  parameter int unsigned SEL_W = 1
) (
  input  logic [SEL_W-1:0]        stim_sel,
  input  logic [n_in(SEL_W)-1:0]  stim_data,
  output logic [tap_w(SEL_W)-1:0] golden
);
  localparam int unsigned N_IN    = n_in(SEL_W);
  localparam int unsigned DATA_OFF = data_off();
  localparam int unsigned SEL_OFF  = sel_off(SEL_W);
  localparam int unsigned DEC_OFF  = dec_off(SEL_W);
  localparam int unsigned AND_OFF  = and_off(SEL_W);
  localparam int unsigned OUT_OFF  = out_off(SEL_W);

  logic [N_IN-1:0] dec;
  logic [N_IN-1:0] and_terms;

  // One-hot select decode and gated data terms.
  always_comb begin
    dec            = '0;
    dec[stim_sel]  = 1'b1;
    and_terms      = stim_data & dec;
  end

  // Assemble the tap bus in its fixed field order.
  always_comb begin
    golden                       = '0;
    golden[DATA_OFF +: N_IN]     = stim_data;
    golden[SEL_OFF +: SEL_W]     = stim_sel;
    golden[DEC_OFF +: N_IN]      = dec;
    golden[AND_OFF +: N_IN]      = and_terms;
    golden[OUT_OFF]              = |and_terms;
  end

endmodule

// File: rtl/mux_diag_engine.sv
// Self-test engine for an N:1 mux: walks every {sel, data} vector, waits
// SETTLE_CYC cycles, compares the tap bus with the golden model and collects
// per-wire mismatch info.
// Optional: MUXDIAG_STOP_ON_FAIL_EN ends the run at the first failing vector.
module mux_diag_engine
  import mux_diag_pkg::*;
#(
  parameter int unsigned SEL_W      = 1,
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  mux_diag_engine_if.slave bus
);
  localparam int unsigned N_IN  = n_in(SEL_W);
  localparam int unsigned VW    = SEL_W + N_IN;
  localparam int unsigned TAP_W = tap_w(SEL_W);
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [VW-1:0]    VecOne  = VW'(1);
  localparam logic [VW:0]      FailOne = (VW + 1)'(1);

  diag_state_e      state_q, state_d;
  logic [VW-1:0]    v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  stim_data_q, stim_data_d;
  logic [SEL_W-1:0] stim_sel_q, stim_sel_d;
  logic [TAP_W-1:0] err_mask_q, err_mask_d;
  logic [VW:0]      fail_cnt_q, fail_cnt_d;
  logic [VW-1:0]    ff_vec_q, ff_vec_d;
  logic             ff_valid_q, ff_valid_d;

  logic [TAP_W-1:0] golden;
  logic [TAP_W-1:0] mism;
  logic             any_mism;

  mux_golden_model #(
    .SEL_W (SEL_W)
  ) u_golden (
    .stim_sel  (stim_sel_q),
    .stim_data (stim_data_q),
    .golden    (golden)
  );

  // Per-wire mismatch of the current vector; only meaningful in StCheck.
  always_comb begin
    mism     = bus.taps ^ golden;
    any_mism = |mism;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    stim_data_d = stim_data_q;
    stim_sel_d  = stim_sel_q;
    err_mask_d  = err_mask_q;
    fail_cnt_d  = fail_cnt_q;
    ff_vec_d    = ff_vec_q;
    ff_valid_d  = ff_valid_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d    = StDrive;
          v_d        = '0;
          err_mask_d = '0;
          fail_cnt_d = '0;
          ff_vec_d   = '0;
          ff_valid_d = 1'b0;
        end
      end
      StDrive: begin
        stim_sel_d  = v_q[VW-1:N_IN];
        stim_data_d = v_q[N_IN-1:0];
        cnt_d       = '0;
        state_d     = StSettle;
      end
      StSettle: begin
        if (cnt_q == CntLast) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StCheck: begin
        if (any_mism) begin
          err_mask_d = err_mask_q | mism;
          fail_cnt_d = fail_cnt_q + FailOne;
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_vec_d   = v_q;
          end
        end
`ifdef MUXDIAG_STOP_ON_FAIL_EN
        if (any_mism || (v_q == '1)) begin
          state_d = StDone;
        end else begin
          v_d     = v_q + VecOne;
          state_d = StDrive;
        end
`else
        if (v_q == '1) begin
          state_d = StDone;
        end else begin
          v_d     = v_q + VecOne;
          state_d = StDrive;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      v_q         <= '0;
      cnt_q       <= '0;
      stim_data_q <= '0;
      stim_sel_q  <= '0;
      err_mask_q  <= '0;
      fail_cnt_q  <= '0;
      ff_vec_q    <= '0;
      ff_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      stim_data_q <= stim_data_d;
      stim_sel_q  <= stim_sel_d;
      err_mask_q  <= err_mask_d;
      fail_cnt_q  <= fail_cnt_d;
      ff_vec_q    <= ff_vec_d;
      ff_valid_q  <= ff_valid_d;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    bus.stim_data        = stim_data_q;
    bus.stim_sel         = stim_sel_q;
    bus.busy             = (state_q == StDrive) || (state_q == StSettle) ||
                           (state_q == StCheck);
    bus.done             = (state_q == StDone);
    bus.pass             = (state_q == StDone) && (fail_cnt_q == '0);
    bus.err_mask         = err_mask_q;
    bus.fail_cnt         = fail_cnt_q;
    bus.first_fail_vec   = ff_vec_q;
    bus.first_fail_valid = ff_valid_q;
  end

endmodule

// File: tb/tb_mux_diag_engine.sv
// Directed bench for mux_diag_engine: SEL_W=1 with injected tap faults and a
// mid-run reset, plus a SEL_W=2 loopback run with an ignored start pulse.
module tb_mux_diag_engine;
  import mux_diag_pkg::*;

  localparam int SETTLE = 2;
`ifdef MUXDIAG_STOP_ON_FAIL_EN
  localparam bit StopEn = 1'b1;
`else
  localparam bit StopEn = 1'b0;
`endif

  typedef struct {
    int          fail_cnt;
    int          first_vec;
    int          first_valid;
    logic [31:0] err_mask;
    int          done_cyc;
    int          last_vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   fault;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mux_diag_engine_if #(.SEL_W(1)) b1 ();
  mux_diag_engine_if #(.SEL_W(2)) b2 ();

  logic [7:0]  gold1;
  logic [7:0]  taps1;
  logic [14:0] gold2;

  mux_diag_engine #(.SEL_W(1), .SETTLE_CYC(SETTLE)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mux_diag_engine #(.SEL_W(2), .SETTLE_CYC(SETTLE)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  mux_golden_model #(.SEL_W(1)) u_mut1 (
    .stim_sel  (b1.stim_sel),
    .stim_data (b1.stim_data),
    .golden    (gold1)
  );
  mux_golden_model #(.SEL_W(2)) u_mut2 (
    .stim_sel  (b2.stim_sel),
    .stim_data (b2.stim_data),
    .golden    (gold2)
  );

  // Fault 1: out stuck-at-0 (bit 7). Fault 2: decode[1] stuck-at-1 (bit 4).
  always_comb begin
    taps1 = gold1;
    if (fault == 1) taps1[7] = 1'b0;
    else if (fault == 2) taps1[4] = 1'b1;
  end
  assign b1.taps = taps1;
  assign b2.taps = gold2;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: builds each vector's expected taps from scratch.
  function automatic exp_t model(input int sel_w, input int flt);
    int   nin;
    int   nvec;
    exp_t e;
    nin           = 1 << sel_w;
    nvec          = 1 << (sel_w + nin);
    e.fail_cnt    = 0;
    e.first_vec   = 0;
    e.first_valid = 0;
    e.err_mask    = '0;
    e.last_vec    = nvec - 1;
    for (int v = 0; v < nvec; v++) begin
      logic [31:0] vv;
      logic [31:0] g;
      logic [31:0] o;
      logic        out;
      int          sel;
      vv  = v;
      sel = v >> nin;
      g   = 32'(sel) << nin;
      out = 1'b0;
      for (int k = 0; k < nin; k++) begin
        g[k]                 = vv[k];
        g[nin + sel_w + k]   = (sel == k);
        g[2*nin + sel_w + k] = vv[k] && (sel == k);
        out                  = out | (vv[k] && (sel == k));
      end
      g[3*nin + sel_w] = out;
      o = g;
      if (flt == 1) o[3*nin + sel_w] = 1'b0;
      else if (flt == 2) o[nin + sel_w + 1] = 1'b1;
      if (o != g) begin
        e.err_mask = e.err_mask | (o ^ g);
        e.fail_cnt++;
        if (e.first_valid == 0) begin
          e.first_valid = 1;
          e.first_vec   = v;
        end
        if (StopEn) begin
          e.last_vec = v;
          break;
        end
      end
    end
    e.done_cyc = (e.last_vec + 1) * (SETTLE + 2) + 1;
    return e;
  endfunction

  task automatic check_zero1(input string tag);
    chk({tag, "_stim"}, {29'd0, b1.stim_sel, b1.stim_data}, 0);
    chk({tag, "_busy"}, 32'(b1.busy), 0);
    chk({tag, "_done"}, 32'(b1.done), 0);
    chk({tag, "_pass"}, 32'(b1.pass), 0);
    chk({tag, "_err_mask"}, 32'(b1.err_mask), 0);
    chk({tag, "_fail_cnt"}, 32'(b1.fail_cnt), 0);
    chk({tag, "_ff_vec"}, 32'(b1.first_fail_vec), 0);
    chk({tag, "_ff_valid"}, 32'(b1.first_fail_valid), 0);
  endtask

  // start is sampled on the next edge (cycle 0); returns #1 into cycle 1.
  task automatic kick1();
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    b1.start = 1'b0;
  endtask

  // Called in cycle 1 of a run; waits for done and scores against the queue.
  task automatic finish1(input string tag);
    int   cyc;
    exp_t e;
    cyc = 1;
    chk({tag, "_busy_c1"}, 32'(b1.busy), 1);
    while (b1.done !== 1'b1 && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(b1.done), 1);
    chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    chk({tag, "_busy_end"}, 32'(b1.busy), 0);
    chk({tag, "_pass"}, 32'(b1.pass), (e.fail_cnt == 0) ? 1 : 0);
    chk({tag, "_err_mask"}, 32'(b1.err_mask), e.err_mask);
    chk({tag, "_fail_cnt"}, 32'(b1.fail_cnt), e.fail_cnt);
    chk({tag, "_ff_vec"}, 32'(b1.first_fail_vec), e.first_vec);
    chk({tag, "_ff_valid"}, 32'(b1.first_fail_valid), e.first_valid);
    chk({tag, "_stim_hold"}, {29'd0, b1.stim_sel, b1.stim_data}, e.last_vec);
  endtask

  initial begin
    int   cyc;
    exp_t e;
    rst      = 1'b1;
    fault    = 0;
    b1.start = 1'b0;
    b2.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero1("reset");
    chk("reset_b2_busy", 32'(b2.busy), 0);
    chk("reset_b2_done", 32'(b2.done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean loopback from IDLE.
    fault = 0;
    sb.push_back(model(1, 0));
    kick1();
    finish1("clean");

    // Out tap stuck-at-0, restarted from DONE.
    fault = 1;
    sb.push_back(model(1, 1));
    kick1();
    finish1("out_sa0");

    // decode[1] tap stuck-at-1.
    fault = 2;
    sb.push_back(model(1, 2));
    kick1();
    finish1("dec1_sa1");

    // Reset during cycle 10 of a clean run, then a full clean rerun.
    fault = 0;
    kick1();
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero1("midrun_rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back(model(1, 0));
    kick1();
    finish1("rerun");

    // SEL_W=2 loopback; a start pulse in cycle 20 must be ignored.
    sb.push_back(model(2, 0));
    b2.start = 1'b1;
    @(posedge clk);
    #1;
    b2.start = 1'b0;
    cyc = 1;
    chk("w2_busy_c1", 32'(b2.busy), 1);
    while (b2.done !== 1'b1 && cyc < 2000) begin
      b2.start = (cyc == 20);
      @(posedge clk);
      #1;
      cyc++;
    end
    b2.start = 1'b0;
    e = sb.pop_front();
    chk("w2_done", 32'(b2.done), 1);
    chk("w2_done_cycle", cyc, e.done_cyc);
    chk("w2_pass", 32'(b2.pass), 1);
    chk("w2_fail_cnt", 32'(b2.fail_cnt), e.fail_cnt);
    chk("w2_err_mask", 32'(b2.err_mask), e.err_mask);
    chk("w2_ff_valid", 32'(b2.first_fail_valid), e.first_valid);
    chk("w2_stim_hold", {26'd0, b2.stim_sel, b2.stim_data}, e.last_vec);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
